// File: rtl/alu_pkg.sv
// Shared ALU/divider definitions: ALU selector codes, divider FSM states,
// and the divider iteration-counter width helper.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_NOT = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_OR  = 3'd4;
  localparam logic [2:0] ALU_XOR = 3'd5;
  localparam logic [2:0] ALU_SLT = 3'd6;
  localparam logic [2:0] ALU_EQ  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // DIV_CNT_W: bits needed to hold the counter value WIDTH
  function automatic int div_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/alu_div_step.sv
// One restoring division step: shift in a dividend bit, trial-subtract.
// Ports: rem (partial remainder), bit_in, divisor -> rem_next, q_bit.
module alu_div_step
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             borrow;

  assign shifted = {rem, bit_in};
  assign diff    = {1'b0, shifted} - {2'b00, divisor};
  // Same borrow sense as the ALU subtract: 1 means shifted < divisor
  assign borrow  = diff[WIDTH+1];
  assign q_bit   = ~borrow;
  // Either branch is below divisor, so the top bit is always zero
  assign rem_next = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];

endmodule

// File: rtl/alu_divider.sv
// Multi-cycle restoring divider with valid/ready request/response.
// Ports: clk, rst_n, in_valid/in_ready, dividend, divisor, [is_signed],
//   out_valid/out_ready, quotient, remainder, div_by_zero, busy.
// Macro ALU_DIVIDER_SIGNED_EN adds is_signed and signed fix-up.
module alu_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef ALU_DIVIDER_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CW = div_cnt_w(WIDTH);

  div_state_t       state;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] dsr_q;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] rem_next;
  logic             q_bit;
  logic [WIDTH-1:0] q_next;

  logic [WIDTH-1:0] a_op;
  logic [WIDTH-1:0] b_op;
  logic             ovf;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

`ifdef ALU_DIVIDER_SIGNED_EN
  logic neg_q;
  logic neg_r;
  logic sn_q;
  logic sn_r;
`endif

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  alu_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .bit_in   (q_q[WIDTH-1]),
    .divisor  (dsr_q),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  assign q_next = {q_q[WIDTH-2:0], q_bit};

  // Operand preparation: magnitudes and overflow detect for signed
  always_comb begin
    a_op = dividend;
    b_op = divisor;
    ovf  = 1'b0;
`ifdef ALU_DIVIDER_SIGNED_EN
    sn_q = 1'b0;
    sn_r = 1'b0;
    if (is_signed) begin
      sn_r = dividend[WIDTH-1];
      sn_q = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      a_op = dividend[WIDTH-1] ? -dividend : dividend;
      b_op = divisor[WIDTH-1] ? -divisor : divisor;
      ovf  = (dividend == {1'b1, {(WIDTH-1){1'b0}}})
           && (&divisor);
    end
`endif
  end

  // Sign fix-up applied on the final step, on the way into DONE
  always_comb begin
    q_fix = q_next;
    r_fix = rem_next;
`ifdef ALU_DIVIDER_SIGNED_EN
    if (neg_q) q_fix = -q_next;
    if (neg_r) r_fix = -rem_next;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rem_q       <= '0;
      q_q         <= '0;
      dsr_q       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      out_valid   <= 1'b0;
`ifdef ALU_DIVIDER_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else if (ovf) begin
              quotient    <= dividend;
              remainder   <= '0;
              div_by_zero <= 1'b0;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else begin
              rem_q       <= '0;
              q_q         <= a_op;
              dsr_q       <= b_op;
              cnt         <= CW'(WIDTH);
              div_by_zero <= 1'b0;
`ifdef ALU_DIVIDER_SIGNED_EN
              neg_q       <= sn_q;
              neg_r       <= sn_r;
`endif
              state       <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_next;
          q_q   <= q_next;
          cnt   <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            quotient  <= q_fix;
            remainder <= r_fix;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_divider.md
Name: alu_divider

Overview:
- Multi-cycle unsigned integer divider; the sequential consumer of the ALU subtract/borrow convention.
- It does not use a combinational select-and-compute path. Each cycle it issues one restoring trial subtraction and uses the borrow to decide the quotient bit.
- Sits beside the ALU in the execute stage. Serves DIV/REM-class instructions through a valid/ready request/response pair.

Parameters:
- WIDTH, 4, operand/result width in bits; must be >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  divider can accept a request.
- dividend  input  WIDTH  numerator; sampled on in_valid & in_ready.
- divisor  input  WIDTH  denominator; sampled on in_valid & in_ready.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  WIDTH  registered quotient.
- remainder  output  WIDTH  registered remainder.
- div_by_zero  output  1  flag: captured divisor was zero.
- busy  output  1  high in CALC or DONE.

Behaviour:
Interface: one clock; reset is asynchronous and active-low, ports named clk and rst_n.

Reset (rst_n low, asynchronous):
- State = IDLE.
- in_ready = 1; out_valid = 0; busy = 0; div_by_zero = 0.
- quotient = 0; remainder = 0; iteration counter = 0.

States:
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: capture operands.
  - Divisor == 0: go directly to DONE next cycle with quotient = all ones, remainder = dividend, div_by_zero = 1.
  - Otherwise: init partial remainder = 0, quotient shift reg = dividend, counter = WIDTH, div_by_zero = 0; go to CALC.
- CALC (one step per cycle, exactly WIDTH cycles):
  - shifted = {rem[WIDTH-1:0], q[WIDTH-1]}, WIDTH+1 bits.
  - Compute diff = shifted - {1'b0, divisor}, WIDTH+2 bits wide. Borrow = diff MSB (1 means shifted < divisor unsigned). This is the same borrow sense as ALU sub carry.
  - No borrow: rem = diff, q = {q[WIDTH-2:0], 1}.
  - Borrow: rem = shifted, q = {q[WIDTH-2:0], 0}.
  - Counter decrements. When counter reaches 1, this step is the last; go to DONE.
- DONE:
  - out_valid = 1; quotient, remainder and div_by_zero are held stable.
  - On out_valid & out_ready: go to IDLE.
  - out_valid must not drop without a handshake.

Latency: accept edge to out_valid = WIDTH+1 cycles for a normal divide; 1 cycle for divide-by-zero.

Timing and boundary rules:
- in_ready is 0 in CALC and DONE; there is no request pipelining.
- In IDLE, a new request is accepted one cycle after the DONE handshake at the earliest. in_ready is combinational from state only, never from out_ready.
- Outputs are registered. quotient/remainder may change during CALC; consumers sample only when out_valid is high.
- Divisor > dividend: quotient 0, remainder = dividend.
- Divisor == 1: quotient = dividend, remainder 0.
- rst_n asserted mid-CALC or mid-DONE: result is abandoned, all outputs return to reset values immediately, and no out_valid pulse follows.

Optional Feature:
ALU_DIVIDER_SIGNED_EN
- With the macro defined: adds input is_signed (1 bit), sampled with the operands.
  - Signed requests divide the magnitudes and then negate the results: quotient negated if the operand signs differ, remainder takes the dividend's sign.
  - Divide-by-zero: quotient all ones, remainder = dividend.
  - Overflow case (dividend = most-negative, divisor = all ones): quotient = dividend, remainder = 0, DONE in 1 cycle, div_by_zero = 0.
  - The sign fix-up is folded into the DONE entry; latency is unchanged.
- Without the macro: the port is absent and all operations are unsigned.

Decomposition:
- Shared package alu_pkg holds:
  - the ALU selector encodings (ADD, SUB, NOT, AND, OR, XOR, SLT, EQ) as localparams, shared with the ALU;
  - the divider state typedef (IDLE, CALC, DONE);
  - the DIV_CNT_W = $clog2(WIDTH+1) helper.
- One sub-module, alu_div_step: a combinational single restoring step. Inputs: partial remainder, incoming dividend bit, divisor. Outputs: next remainder and quotient bit.
- FSM, counter and handshake registers stay in alu_divider.

Test Plan (all WIDTH=4):
- dividend=13, divisor=3 -> out_valid after 5 cycles; quotient=4, remainder=1, div_by_zero=0.
- dividend=7, divisor=0 -> out_valid after 1 cycle; quotient=15, remainder=7, div_by_zero=1.
- dividend=2, divisor=9 -> quotient=0, remainder=2. Then dividend=15, divisor=1 -> quotient=15, remainder=0.
- Result ready, out_ready held 0 for 3 cycles -> out_valid stays 1 with quotient/remainder stable, in_ready stays 0; accepted on the first out_ready=1 cycle, then IDLE.
- rst_n pulsed low during CALC (cycle 2 of 4) -> outputs zero asynchronously, in_ready=1, no out_valid. A new request 12/4 then yields quotient=3, remainder=0.
- With ALU_DIVIDER_SIGNED_EN: -7/2 signed -> quotient=-3 (4'hD), remainder=-1 (4'hF). Then -8/-1 -> quotient=-8 (4'h8), remainder=0, 1-cycle latency.
